// File: rtl/sram_controller.sv
// Drives a 16-bit asynchronous SRAM for 32-bit MEM-stage loads and stores.
// Each word is accessed as two half-words followed by wait states. The macro
// SRAM_RD_HIT_EN enables a one-entry read buffer that answers repeated loads
// of the same word without touching the SRAM.
module sram_controller #(
    parameter int ACCESS_CYCLES = 6,
    parameter int BASE_ADDR     = 1024,
    parameter int SRAM_ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_o,
    input  logic [15:0]            sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);
    localparam int W_W = SRAM_ADDR_W - 1;
    localparam logic [3:0] WAIT_LOAD = (ACCESS_CYCLES > 4) ? 4'(ACCESS_CYCLES - 5) : 4'd0;

    typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [W_W-1:0]         w_reg;
    logic [W_W-1:0]         w_in;
    logic [31:0]            wdata_reg;
    logic                   write_reg;
    logic [31:0]            read_data_reg;
    logic [SRAM_ADDR_W-1:0] addr_hold_reg;
    logic [15:0]            dq_hold_reg;
    logic                   hit;
    logic                   start;

    // Word index; out-of-range addresses wrap into the SRAM silently.
    assign w_in  = W_W'((address - 32'(BASE_ADDR)) >> 2);
    assign start = (state_reg == IDLE) && (rd_en || wr_en) && !hit;
    assign ready = !(rd_en || wr_en) || (state_reg == DONE) || hit;

`ifdef SRAM_RD_HIT_EN
    logic           buf_valid_reg;
    logic [W_W-1:0] buf_w_reg;
    logic [31:0]    buf_data_reg;

    assign hit = (state_reg == IDLE) && rd_en && !wr_en && buf_valid_reg && (buf_w_reg == w_in);
    assign read_data = hit ? buf_data_reg : read_data_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_reg <= 1'b0;
            buf_w_reg     <= '0;
            buf_data_reg  <= '0;
        end else if (state_reg == DONE) begin
            if (!write_reg) begin
                buf_valid_reg <= 1'b1;
                buf_w_reg     <= w_reg;
                buf_data_reg  <= read_data_reg;
            end else if (buf_valid_reg && (buf_w_reg == w_reg)) begin
                buf_data_reg  <= wdata_reg;
            end
        end
    end
`else
    assign hit       = 1'b0;
    assign read_data = read_data_reg;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sram_addr  = addr_hold_reg;
        sram_dq_o  = dq_hold_reg;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        case (state_reg)
            IDLE: if (start) state_next = LO;
            LO: begin
                sram_addr  = {w_reg, 1'b0};
                sram_dq_o  = wdata_reg[15:0];
                sram_dq_oe = write_reg;
                sram_we_n  = !write_reg;
                state_next = HI;
            end
            HI: begin
                sram_addr  = {w_reg, 1'b1};
                sram_dq_o  = wdata_reg[31:16];
                sram_dq_oe = write_reg;
                sram_we_n  = !write_reg;
                if (ACCESS_CYCLES > 4) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    state_next = DONE;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) state_next = DONE;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            w_reg         <= '0;
            wdata_reg     <= '0;
            write_reg     <= 1'b0;
            read_data_reg <= '0;
            addr_hold_reg <= '0;
            dq_hold_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_hold_reg <= sram_addr;
            dq_hold_reg   <= sram_dq_o;
            if (start) begin
                w_reg     <= w_in;
                wdata_reg <= write_data;
                write_reg <= wr_en;
            end
            // The SRAM is asynchronous, so its data is sampled in the same cycle.
            if (state_reg == LO && !write_reg) read_data_reg[15:0]  <= sram_dq_i;
            if (state_reg == HI && !write_reg) read_data_reg[31:16] <= sram_dq_i;
`ifdef SRAM_RD_HIT_EN
            if (hit) read_data_reg <= buf_data_reg;
`endif
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: an SRAM device model, a word-level
// reference memory, directed cases and randomized load/store traffic.
module tb_sram_controller;
    localparam int AC    = 6;
    localparam int NHALF = 262144;
    localparam int NWORD = 131072;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic [15:0] sram_mem [0:NHALF-1];
    logic [31:0] ref_mem  [0:NWORD-1];
    logic [31:0] exp_rdata = '0;
    bit          hv = 1'b0;
    int          hw = 0;
    int          err_cnt = 0;
    int          chk_cnt = 0;

    sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(1024), .SRAM_ADDR_W(18)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM device: combinational read, write on the strobe.
    assign sram_dq_i = sram_mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'd1024;
        return int'((off >> 2) % 32'(NWORD));
    endfunction

    task automatic do_op(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
        int  w, zeros, wecnt;
        bit  done, hit_exp;
        w = word_of(addr);
`ifdef SRAM_RD_HIT_EN
        hit_exp = !wr && hv && (hw == w);
`else
        hit_exp = 1'b0;
`endif
        if (wr) ref_mem[w] = data;
        else    exp_rdata = ref_mem[w];
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        zeros = 0; wecnt = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                check("dq_oe", {31'd0, sram_dq_oe}, 32'd1);
                check(wecnt == 0 ? "lo_addr" : "hi_addr", {14'd0, sram_addr}, 32'(2 * w + wecnt));
                check(wecnt == 0 ? "lo_data" : "hi_data", {16'd0, sram_dq_o},
                      wecnt == 0 ? {16'd0, data[15:0]} : {16'd0, data[31:16]});
                wecnt++;
            end
            if (ready) begin
                done = 1'b1;
                check("rdata", read_data, exp_rdata);
            end else begin
                zeros++;
            end
            @(posedge clk); #1;
        end
        rd_en = 1'b0; wr_en = 1'b0;
        check("no_timeout", {31'd0, done}, 32'd1);
        check("latency", 32'(zeros), hit_exp ? 32'd0 : 32'(AC - 1));
        check("we_cycles", 32'(wecnt), wr ? 32'd2 : 32'd0);
        if (!wr && !hit_exp) begin hv = 1'b1; hw = w; end
        $display("op wr=%0b rd=%0b addr=0x%08h data=0x%08h w=%0d stall=%0d rdata=0x%08h",
                 wr, rd, addr, data, w, zeros, read_data);
    endtask

    initial begin
        int w, wecnt;
        logic [31:0] a, d;
        for (int i = 0; i < NHALF; i++) sram_mem[i] = '0;
        for (int i = 0; i < NWORD; i++) ref_mem[i] = '0;

        // Reset held with a pending write.
        rst = 1'b0; wr_en = 1'b1; address = 32'd1032; write_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_addr", {14'd0, sram_addr}, 32'd0);
        @(posedge clk); #1;

        // Directed: write, read-back, repeated read, overwrite, simultaneous.
        do_op(1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF);
        check("mem4", {16'd0, sram_mem[4]}, 32'h0000_BEEF);
        check("mem5", {16'd0, sram_mem[5]}, 32'h0000_DEAD);
        do_op(1'b0, 1'b1, 32'd1032, 32'd0);
        @(negedge clk);
        check("rdata_held", read_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        do_op(1'b0, 1'b1, 32'd1032, 32'd0);
        do_op(1'b1, 1'b0, 32'd1032, 32'd0);
        do_op(1'b0, 1'b1, 32'd1032, 32'd0);
        do_op(1'b1, 1'b1, 32'd1024, 32'h1234_5678);
        check("mem0", {16'd0, sram_mem[0]}, 32'h0000_5678);
        check("mem1", {16'd0, sram_mem[1]}, 32'h0000_1234);

        // Write dropped during LO still completes.
        d = $urandom;
        wr_en = 1'b1; address = 32'd1024 + 32'd80; write_data = d;
        ref_mem[20] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wecnt = 0;
        for (int k = 0; k < AC - 1; k++) begin
            @(negedge clk);
            if (k == 0) check("drop_ready", {31'd0, ready}, 32'd1);
            if (!sram_we_n) wecnt++;
            @(posedge clk); #1;
        end
        check("drop_we_cycles", 32'(wecnt), 32'd2);
        check("drop_mem_lo", {16'd0, sram_mem[40]}, {16'd0, d[15:0]});
        check("drop_mem_hi", {16'd0, sram_mem[41]}, {16'd0, d[31:16]});
        $display("op dropped write addr=0x%08h data=0x%08h we_cycles=%0d", 32'd1104, d, wecnt);

        // Reset during the WAIT of a read.
        rd_en = 1'b1; address = 32'd1024 + 32'd124;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; rd_en = 1'b0;
        exp_rdata = '0; hv = 1'b0;
        @(negedge clk);
        check("abort_rdata", read_data, 32'd0);
        check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        $display("op reset during read wait: rdata=0x%08h", read_data);
        @(posedge clk); #1;
        do_op(1'b0, 1'b1, 32'd1032, 32'd0);

        // Randomized traffic, including addresses below the base that wrap.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'd1024 - 32'(4 * $urandom_range(1, 3)) + 32'($urandom_range(0, 3));
            else
                a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            d = $urandom;
            case ($urandom_range(0, 2))
                0:       do_op(1'b1, 1'b0, a, d);
                1:       do_op(1'b0, 1'b1, a, d);
                default: do_op(1'b1, 1'b1, a, d);
            endcase
        end
        w = word_of(32'd1020);
        check("wrap_index", 32'(w), 32'd131071);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Replaces the on-chip data memory behind the MEM stage with an off-chip 16-bit asynchronous SRAM.
- Takes the MEM-stage read/write request: ALU result as byte address, Rm value as write data.
- Performs each 32-bit word access as two 16-bit SRAM half-word accesses plus wait states.
- Drives ready low while busy; the top level uses ~ready to freeze all pipeline registers.

Parameters:
- ACCESS_CYCLES, 6, total cycles a request occupies, including the ready-high cycle; legal range 4..16.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18, SRAM half-word address width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- rd_en  input  1  MEM-stage read request (LDR).
- wr_en  input  1  MEM-stage write request (STR).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (Val_Rm).
- read_data  output  32  loaded word, registered.
- ready  output  1  combinational; 0 means freeze pipeline.
- sram_addr  output  SRAM_ADDR_W  SRAM half-word address.
- sram_dq_o  output  16  SRAM write data.
- sram_dq_i  input  16  SRAM read data; async SRAM, valid in the same cycle.
- sram_dq_oe  output  1  data bus drive enable.
- sram_we_n  output  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, read_data=0, latched address/data=0, wait counter=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - Reset mid-access aborts the access; the bus is released by the next cycle. No partial-write recovery.
- Word index: w = ((address - BASE_ADDR) mod 2^32) >> 2, truncated to SRAM_ADDR_W-1 bits. Out-of-range addresses wrap silently.
- Half-word addresses: lo = {w,0}, hi = {w,1}. Bits [15:0] go to lo, [31:16] to hi.
- States: IDLE, LO, HI, WAIT, DONE.
- IDLE:
  - If wr_en or rd_en: latch address, write_data and op; go to LO.
  - If both are set: the write wins.
  - Otherwise remain in IDLE.
- LO:
  - Drive sram_addr=lo.
  - Write: sram_dq_o=wdata[15:0], sram_dq_oe=1, sram_we_n=0.
  - Read: capture sram_dq_i into read_data[15:0] at the edge.
  - Go to HI.
- HI:
  - Same as LO using the hi address and bits [31:16].
  - Go to WAIT if ACCESS_CYCLES>4, else DONE. On WAIT entry the counter loads ACCESS_CYCLES-5.
- WAIT:
  - sram_we_n=1, sram_dq_oe=0.
  - Counter decrements each cycle; go to DONE when it reaches 0. WAIT therefore lasts ACCESS_CYCLES-4 cycles.
- DONE:
  - Bus idle; read_data holds the full word.
  - Go to IDLE. The pipeline advances on this edge.
- In IDLE, WAIT and DONE: sram_we_n=1 and sram_dq_oe=0.
- sram_addr and sram_dq_o are decoded from the state and latched registers. They hold their last value when idle.
- ready = ~(rd_en | wr_en) | (state==DONE).
  - A request therefore sees ready=0 for ACCESS_CYCLES-1 cycles and ready=1 in its final cycle.
- A request that is dropped mid-access still runs to DONE; a write is never truncated. ready follows the formula.
- Requests outside IDLE are not re-latched; inputs are ignored until the next IDLE.
- Back-to-back requests: the cycle after DONE is IDLE and samples the new request, so no idle bubble beyond DONE.
- read_data changes only on read captures; writes leave it unchanged.

Optional Feature:
- Macro: SRAM_RD_HIT_EN.
- Defined:
  - One-entry buffer {valid, w, data}; valid is cleared on reset.
  - The buffer is filled at DONE of every read. A write to the same w at DONE updates the data; valid stays set.
  - In IDLE, a read (with wr_en=0) whose w matches the buffered w with valid=1 is a hit:
    - ready=1 in the same cycle.
    - read_data is driven combinationally from the buffer and registered at the edge.
    - No SRAM access; the state stays IDLE.
- Undefined: no buffer; every read takes ACCESS_CYCLES.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wr_en=1 -> sram_we_n=1, sram_dq_oe=0, read_data=0, state IDLE; after release with no request, ready=1.
- Write timing: wr_en=1, address=1032, write_data=0xDEADBEEF -> LO cycle sram_addr=4, dq_o=0xBEEF, we_n=0; HI cycle sram_addr=5, dq_o=0xDEAD; ready=0 for 5 cycles, 1 on the 6th; model holds mem[4]=0xBEEF, mem[5]=0xDEAD.
- Read-back: rd_en=1, address=1032 after the write -> ready low 5 cycles, read_data=0xDEADBEEF in the DONE cycle and held afterwards.
- Simultaneous/abort: rd_en=wr_en=1, address=1024, write_data=0x12345678 -> write performed (mem[0]=0x5678, mem[1]=0x1234). Separately, deassert wr_en in the LO cycle -> HI write still occurs, then DONE.
- Reset mid-op: rst=0 during the WAIT of a read -> next cycle IDLE, read_data=0, we_n=1.
- With SRAM_RD_HIT_EN: two consecutive reads of 1032 -> second has ready=1 in its first cycle and read_data=0xDEADBEEF. A write of 0x0 to 1032, then a read -> hit returns 0x00000000.
